// File: rtl/hwpe_stream_merge_buffered.sv
// hwpe_stream_merge_buffered
// Merges NB_IN_STREAMS narrow streams into one wide stream. Each input has a
// private FIFO. Inputs may therefore arrive skewed in time, and each input's
// ready depends only on its own FIFO occupancy. The output presents the heads
// of all FIFOs side by side (input 0 in the LSBs). A merged word is valid only
// when every FIFO holds at least one entry, and a pop drains all FIFOs together.

module hwpe_stream_merge_buffered #(
  parameter int unsigned NB_IN_STREAMS = 2,
  parameter int unsigned DATA_WIDTH_IN = 32,
  parameter int unsigned FIFO_DEPTH    = 2
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic                                       clear_i,

  // Sink side: one narrow stream per input, packed with input 0 in the LSBs
  input  logic [NB_IN_STREAMS*DATA_WIDTH_IN-1:0]     push_data_i,
  input  logic [NB_IN_STREAMS*DATA_WIDTH_IN/8-1:0]   push_strb_i,
  input  logic [NB_IN_STREAMS-1:0]                   push_valid_i,
  output logic [NB_IN_STREAMS-1:0]                   push_ready_o,

  // Source side: merged wide stream
  output logic [NB_IN_STREAMS*DATA_WIDTH_IN-1:0]     pop_data_o,
  output logic [NB_IN_STREAMS*DATA_WIDTH_IN/8-1:0]   pop_strb_o,
  output logic                                       pop_valid_o,
  input  logic                                       pop_ready_i,

  // Per-input FIFO status
  output logic [NB_IN_STREAMS-1:0]                   empty_o,
  output logic [NB_IN_STREAMS-1:0]                   full_o
);

  localparam int unsigned STRB_W  = DATA_WIDTH_IN / 8;
  localparam int unsigned ENTRY_W = DATA_WIDTH_IN + STRB_W;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;

  // A merged pop consumes one entry from every FIFO at once.
  logic pop_hs;

  assign pop_valid_o = &(~empty_o);
  assign pop_hs      = pop_valid_o & pop_ready_i;

  for (genvar i = 0; i < NB_IN_STREAMS; i++) begin : g_fifo
    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [CNT_W-1:0]   cnt_q,  cnt_d;
    logic               push_hs;
    logic [ENTRY_W-1:0] head;

    // Flags come straight from the registered count. This keeps ready free
    // of any combinational path from pop_ready_i or push_valid_i.
    assign full_o[i]       = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign empty_o[i]      = (cnt_q == '0);
    assign push_ready_o[i] = ~full_o[i];
    assign push_hs         = push_valid_i[i] & ~full_o[i];

    // Next-state pointers and occupancy; clear overrides any handshake
    always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (clear_i) begin
        wptr_d = '0;
        rptr_d = '0;
        cnt_d  = '0;
      end else begin
        if (push_hs) wptr_d = wptr_q + PTR_W'(1);
        if (pop_hs)  rptr_d = rptr_q + PTR_W'(1);
        case ({push_hs, pop_hs})
          2'b10:   cnt_d = cnt_q + CNT_W'(1);
          2'b01:   cnt_d = cnt_q - CNT_W'(1);
          default: cnt_d = cnt_q;
        endcase
      end
    end

    // Control state: pointers and count, cleared asynchronously by reset
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
        cnt_q  <= cnt_d;
      end
    end

    // Storage is not reset; only entries between rptr and wptr are meaningful
    always_ff @(posedge clk_i) begin
      if (push_hs && !clear_i) begin
        mem_q[wptr_q] <= {push_strb_i[i*STRB_W +: STRB_W],
                          push_data_i[i*DATA_WIDTH_IN +: DATA_WIDTH_IN]};
      end
    end

    // The head stays fixed until a pop, because pushes only write behind it
    assign head = mem_q[rptr_q];
    assign pop_data_o[i*DATA_WIDTH_IN +: DATA_WIDTH_IN] = head[DATA_WIDTH_IN-1:0];
    assign pop_strb_o[i*STRB_W +: STRB_W]               = head[ENTRY_W-1:DATA_WIDTH_IN];
  end

endmodule

// File: tb/tb_hwpe_stream_merge_buffered.sv
// Scoreboard bench for hwpe_stream_merge_buffered (N=2, W=32, D=2).
// Stimulus pushes the expected merged word into a queue. A monitor on the
// falling edge pops and compares it whenever an output handshake occurs.

module tb_hwpe_stream_merge_buffered;

  localparam int N = 2;
  localparam int W = 32;
  localparam int D = 2;

  logic             clk_i;
  logic             rst_i;
  logic             clear_i;
  logic [N*W-1:0]   push_data_i;
  logic [N*W/8-1:0] push_strb_i;
  logic [N-1:0]     push_valid_i;
  logic [N-1:0]     push_ready_o;
  logic [N*W-1:0]   pop_data_o;
  logic [N*W/8-1:0] pop_strb_o;
  logic             pop_valid_o;
  logic             pop_ready_i;
  logic [N-1:0]     empty_o;
  logic [N-1:0]     full_o;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  strb;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  hwpe_stream_merge_buffered #(
    .NB_IN_STREAMS(N),
    .DATA_WIDTH_IN(W),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .push_data_i (push_data_i),
    .push_strb_i (push_strb_i),
    .push_valid_i(push_valid_i),
    .push_ready_o(push_ready_o),
    .pop_data_o  (pop_data_o),
    .pop_strb_o  (pop_strb_o),
    .pop_valid_o (pop_valid_o),
    .pop_ready_i (pop_ready_i),
    .empty_o     (empty_o),
    .full_o      (full_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_word(input logic [63:0] d, input logic [7:0] s);
    exp_t e;
    e.data = d;
    e.strb = s;
    exp_q.push_back(e);
  endtask

  // Monitor: every output handshake must match the oldest expected word
  always @(negedge clk_i) begin
    if (!rst_i && !clear_i && pop_valid_o && pop_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %h/%h expected no word", pop_data_o, pop_strb_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (pop_data_o !== mon_e.data || pop_strb_o !== mon_e.strb) begin
          errors++;
          $display("FAIL pop_word: got %h/%h expected %h/%h",
                   pop_data_o, pop_strb_o, mon_e.data, mon_e.strb);
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i        = 1'b1;
    clear_i      = 1'b0;
    push_data_i  = '0;
    push_strb_i  = '0;
    push_valid_i = '0;
    pop_ready_i  = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    tick();

    // ---------------- asynchronous reset mid-operation ----------------
    push_valid_i = 2'b11;
    push_data_i  = {32'h5555_0002, 32'h5555_0001};
    push_strb_i  = 8'hFF;
    tick();
    push_valid_i = 2'b00;
    chk("pre_reset_valid", {63'd0, pop_valid_o}, 64'd1);
    chk("pre_reset_empty", {62'd0, empty_o}, 64'd0);
    #2 rst_i = 1'b1;
    #1;
    chk("async_reset_valid", {63'd0, pop_valid_o}, 64'd0);
    chk("async_reset_ready", {62'd0, push_ready_o}, 64'h3);
    chk("async_reset_empty", {62'd0, empty_o}, 64'h3);
    chk("async_reset_full", {62'd0, full_o}, 64'h0);
    tick();
    rst_i = 1'b0;
    tick();

    // ---------------- aligned merge ----------------
    pop_ready_i  = 1'b1;
    push_valid_i = 2'b11;
    push_data_i  = {32'hBBBB_0001, 32'hAAAA_0001};
    push_strb_i  = 8'hFF;
    expect_word(64'hBBBB_0001_AAAA_0001, 8'hFF);
    tick();
    push_valid_i = 2'b00;
    chk("aligned_valid_c1", {63'd0, pop_valid_o}, 64'd1);
    tick();
    chk("aligned_empty_after", {62'd0, empty_o}, 64'h3);

    // ---------------- skewed inputs ----------------
    push_valid_i = 2'b01;
    push_data_i  = {32'h0, 32'h0000_0011};
    push_strb_i  = 8'h03;
    expect_word({32'h0000_0022, 32'h0000_0011}, 8'hC3);
    tick();
    push_valid_i = 2'b00;
    chk("skew_valid_c1", {63'd0, pop_valid_o}, 64'd0);
    tick();
    chk("skew_valid_c2", {63'd0, pop_valid_o}, 64'd0);
    tick();
    chk("skew_valid_c3", {63'd0, pop_valid_o}, 64'd0);
    push_valid_i = 2'b10;
    push_data_i  = {32'h0000_0022, 32'h0};
    push_strb_i  = 8'hC0;
    tick();
    push_valid_i = 2'b00;
    chk("skew_valid_c4", {63'd0, pop_valid_o}, 64'd1);
    tick();
    chk("skew_empty_after", {62'd0, empty_o}, 64'h3);

    // ---------------- backpressure / full ----------------
    pop_ready_i  = 1'b0;
    push_strb_i  = 8'hFF;
    push_valid_i = 2'b11;
    push_data_i  = {32'hB000_0001, 32'hA000_0001};
    expect_word(64'hB000_0001_A000_0001, 8'hFF);
    chk("bp_ready0_w1", {63'd0, push_ready_o[0]}, 64'd1);
    tick();
    push_data_i  = {32'hB000_0002, 32'hA000_0002};
    expect_word(64'hB000_0002_A000_0002, 8'hFF);
    chk("bp_ready0_w2", {63'd0, push_ready_o[0]}, 64'd1);
    tick();
    push_valid_i = 2'b01;
    push_data_i  = {32'h0, 32'hA000_0003};
    chk("bp_full_w3", {62'd0, full_o}, 64'h3);
    chk("bp_ready0_w3", {63'd0, push_ready_o[0]}, 64'd0);
    pop_ready_i = 1'b1;
    tick();
    chk("bp_ready0_after_pop", {63'd0, push_ready_o[0]}, 64'd1);
    push_valid_i = 2'b11;
    push_data_i  = {32'hB000_0003, 32'hA000_0003};
    expect_word(64'hB000_0003_A000_0003, 8'hFF);
    tick();
    push_valid_i = 2'b00;
    tick();
    chk("bp_empty_after", {62'd0, empty_o}, 64'h3);

    // ---------------- streaming 100 words ----------------
    pop_ready_i = 1'b1;
    push_strb_i = 8'hFF;
    for (int k = 0; k < 100; k++) begin
      push_valid_i = 2'b11;
      push_data_i  = {32'h0200_0000 + 32'(k), 32'h0100_0000 + 32'(k)};
      expect_word({32'h0200_0000 + 32'(k), 32'h0100_0000 + 32'(k)}, 8'hFF);
      tick();
      if (k == 50) chk("stream_valid_mid", {63'd0, pop_valid_o}, 64'd1);
    end
    push_valid_i = 2'b00;
    tick();
    tick();
    chk("stream_drained", 64'(exp_q.size()), 64'd0);
    chk("stream_empty_after", {62'd0, empty_o}, 64'h3);

    // ---------------- clear mid-operation ----------------
    pop_ready_i  = 1'b0;
    push_valid_i = 2'b01;
    push_data_i  = {32'h0, 32'hC000_0001};
    tick();
    push_data_i  = {32'h0, 32'hC000_0002};
    tick();
    chk("clr_full_before", {62'd0, full_o}, 64'h1);
    clear_i      = 1'b1;
    push_valid_i = 2'b10;
    push_data_i  = {32'hDEAD_BEEF, 32'h0};
    tick();
    clear_i      = 1'b0;
    push_valid_i = 2'b00;
    chk("clr_empty", {62'd0, empty_o}, 64'h3);
    chk("clr_full", {62'd0, full_o}, 64'h0);
    chk("clr_valid", {63'd0, pop_valid_o}, 64'd0);
    pop_ready_i  = 1'b1;
    push_valid_i = 2'b11;
    push_data_i  = {32'hE000_0002, 32'hE000_0001};
    push_strb_i  = 8'h5A;
    expect_word(64'hE000_0002_E000_0001, 8'h5A);
    tick();
    push_valid_i = 2'b00;
    chk("clr_merge_valid", {63'd0, pop_valid_o}, 64'd1);
    tick();
    tick();
    chk("final_drained", 64'(exp_q.size()), 64'd0);
    chk("final_empty", {62'd0, empty_o}, 64'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hwpe_stream_merge_buffered.md
Name: hwpe_stream_merge_buffered

Overview:
Merges NB_IN_STREAMS input HWPE-Streams into one wide output stream. Each input has its own small FIFO, so the inputs do not need to be valid in the same cycle. Each input gets its own ready that does not depend on the output ready, which breaks the combinational ready broadcast. Intended between multiple TCDM load ports with skewed grant latency and a wide engine-side consumer.

Parameters:
NB_IN_STREAMS, 2, number of input streams (≥1)
DATA_WIDTH_IN, 32, data width per input stream (multiple of 8)
FIFO_DEPTH, 2, entries per input FIFO (power of 2, ≥2)

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  asynchronous, active-high reset
clear_i  input  1  synchronous flush of all FIFOs
push_i[NB_IN_STREAMS-1:0]  sink interface  data DATA_WIDTH_IN, strb DATA_WIDTH_IN/8, valid 1, ready 1  input streams
pop_o  source interface  data NB_IN_STREAMS*DATA_WIDTH_IN, strb NB_IN_STREAMS*DATA_WIDTH_IN/8, valid 1, ready 1  merged stream
empty_o  output  NB_IN_STREAMS  per-input FIFO empty flag
full_o  output  NB_IN_STREAMS  per-input FIFO full flag

Behaviour:
- Per input i: a FIFO of FIFO_DEPTH entries {data, strb}, with read pointer, write pointer and occupancy counter (width $clog2(FIFO_DEPTH)+1). Pointers wrap modulo FIFO_DEPTH.
- push_i[i].ready = !full_o[i]. It is purely registered and has no combinational path from pop_o.ready or push_i[i].valid.
- Push handshake i: push_i[i].valid && push_i[i].ready. Writes the head of the write pointer and increments it.
- pop_o.valid = AND over i of !empty_o[i].
- pop_o.data[(i+1)*DATA_WIDTH_IN-1 : i*DATA_WIDTH_IN] = head data of FIFO i. strb is packed the same way. Input 0 is in the LSBs.
- Pop handshake: pop_o.valid && pop_o.ready. It pops every FIFO in the same cycle.
- No FIFO is ever popped alone. A partially filled set waits, and pop_o.data/strb are don't-care while pop_o.valid=0.
- Latency: a word pushed into an empty FIFO appears at the head in the next cycle. With all inputs pushed in cycle t, pop_o.valid=1 in cycle t+1.
- Throughput: 1 merged word per cycle in steady state when FIFO_DEPTH≥2.
- Simultaneous push and pop on FIFO i: occupancy is unchanged and both pointers advance.
- Full FIFO: ready is already low, so no push is accepted. A pop in the same cycle frees the slot for the next cycle only.
- Empty FIFO: no pop is possible, because pop_o.valid=0.
- Output stability: while pop_o.valid=1 and pop_o.ready=0, pop_o.data/strb/valid hold stable. Upstream pushes only append behind the head, so this holds by construction.
- clear_i=1:
  - all pointers and counters go to 0 on the next edge, and the FIFOs are empty.
  - any push or pop handshakes in that cycle are discarded.
  - clear_i has priority over everything.
- Reset (rst_i=1, at any time, including mid-transfer):
  - pointers and counters go to 0 immediately.
  - empty_o = all 1, full_o = all 0, pop_o.valid = 0, push_i[*].ready = 1.
  - FIFO storage is not reset; its contents are don't-care.
- NB_IN_STREAMS=1 degenerates to a plain FIFO with the same timing.

Test Plan:
- Reset check (N=2, W=32, D=2): assert rst_i asynchronously between edges -> pop_o.valid=0, push_i[*].ready=1 and empty_o=2'b11 without waiting for a clock edge.
- Aligned merge: push 0xAAAA0001 on in0 and 0xBBBB0001 on in1 in cycle 0, with pop_o.ready=1 -> cycle 1 shows pop_o.valid=1, data=0xBBBB0001_AAAA0001, strb=8'hFF.
- Skewed inputs: in0 pushes 0x11 at cycle 0; in1 pushes 0x22 at cycle 3.
  - cycles 1-3: pop_o.valid=0.
  - cycle 4: pop_o.valid=1, data={0x22,0x11}.
  - after that pop, empty_o=2'b11.
- Backpressure/full: hold pop_o.ready=0 and push 3 words on in0 -> first 2 are accepted, full_o[0]=1, push_i[0].ready=0 on the 3rd. Release ready -> ready returns 1 one cycle after the first pop. Words emerge in order.
- Streaming: both inputs valid every cycle with incrementing data, pop_o.ready=1 -> after 1-cycle fill, 1 merged word per cycle, no drops or duplicates over 100 words.
- Clear mid-operation: fill in0 with 2 words, then assert clear_i together with push_i[1].valid -> next cycle empty_o=2'b11 and the in1 word is discarded. A subsequent aligned push merges correctly.
